// File: rtl/trace_match_recorder_pkg.sv
// Shared types and packed-entry layout for the trace match recorder.
// Entry layout, LSB first: buffer | multi | rule | timestamp.
package trace_match_recorder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } rec_state_e;

    function automatic int entry_width(input int ts_w, input int rule_w, input int buf_w);
        return ts_w + rule_w + 1 + buf_w;
    endfunction

    function automatic int buffer_offset();
        return 0;
    endfunction

    function automatic int multi_offset(input int buf_w);
        return buf_w;
    endfunction

    function automatic int rule_offset(input int buf_w);
        return buf_w + 1;
    endfunction

    function automatic int ts_offset(input int rule_w, input int buf_w);
        return buf_w + 1 + rule_w;
    endfunction

endpackage

// File: rtl/trace_event_fifo.sv
// Single-clock first-word-fall-through FIFO; head data reads as zero while empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module trace_event_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count   = wr_ptr_q - rd_ptr_q;
        do_pop  = pop && !empty && !flush;
        do_push = push && (!full || do_pop) && !flush;
        rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the empty mask hides stale words.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/trace_match_recorder.sv
// Timestamps rising edges of the trigger match vector and queues them for software.
//   state | meaning
//   IDLE  | not recording
//   ARMED | recording new match events
//   DONE  | stopped (event limit reached or full with stop-on-full)
module trace_match_recorder
    import trace_match_recorder_pkg::*;
#(
    parameter int pBUFFER_SIZE = 64,
    parameter int pMATCH_RULES = 8,
    parameter int pTS_WIDTH    = 32,
    parameter int pFIFO_DEPTH  = 16
) (
    input  logic                             trace_clk,
    input  logic                             reset,
    input  logic                             I_arm,
    input  logic                             I_disarm,
    input  logic                             I_clear,
    input  logic                             I_stop_on_full,
    input  logic [7:0]                       I_max_events,
    input  logic                             I_synchronized,
    input  logic [pMATCH_RULES-1:0]          I_matching_pattern,
    input  logic [pBUFFER_SIZE-1:0]          I_matching_buffer,
    input  logic                             I_rd_en,
    output logic [pTS_WIDTH-1:0]             O_rd_timestamp,
    output logic [$clog2(pMATCH_RULES)-1:0]  O_rd_rule,
    output logic                             O_rd_multi,
    output logic [pBUFFER_SIZE-1:0]          O_rd_buffer,
    output logic                             O_empty,
    output logic                             O_full,
    output logic [$clog2(pFIFO_DEPTH):0]     O_count,
    output logic                             O_overflow,
    output logic [7:0]                       O_drop_count,
    output logic [1:0]                       O_state,
    output logic [pTS_WIDTH-1:0]             O_timestamp
);
    localparam int RW   = $clog2(pMATCH_RULES);
    localparam int EW   = entry_width(pTS_WIDTH, RW, pBUFFER_SIZE);
    localparam int BOFF = buffer_offset();
    localparam int MOFF = multi_offset(pBUFFER_SIZE);
    localparam int ROFF = rule_offset(pBUFFER_SIZE);
    localparam int TOFF = ts_offset(RW, pBUFFER_SIZE);

    rec_state_e               state_q, state_d;
    logic [pTS_WIDTH-1:0]     ts_q, ts_d;
    logic [pMATCH_RULES-1:0]  prev_q, prev_d;
    logic [7:0]               ev_cnt_q, ev_cnt_d;
    logic                     ovf_q, ovf_d;
    logic [7:0]               drop_q, drop_d;

    logic [pMATCH_RULES-1:0]  new_bits;
    logic [RW-1:0]            ev_rule;
    logic                     ev_multi;
    logic                     event_ok;
    logic                     pop_ok;
    logic                     push;
    logic                     drop;
    logic [EW-1:0]            wr_entry;
    logic [EW-1:0]            rd_entry;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [7:0]               ev_cnt_inc;

    always_comb begin
        new_bits = I_matching_pattern & ~prev_q;
        ev_rule  = '0;
        for (int i = pMATCH_RULES - 1; i >= 0; i--) begin
            if (new_bits[i]) ev_rule = i[RW-1:0];
        end
        ev_multi = (new_bits & (new_bits - pMATCH_RULES'(1))) != '0;

        // Any control pulse outranks an event in the same cycle.
        event_ok = (new_bits != '0) && (state_q == ST_ARMED) && I_synchronized
                   && !I_clear && !I_disarm && !I_arm;
        pop_ok   = I_rd_en && !fifo_empty && !I_clear;
        push     = event_ok && (!fifo_full || pop_ok);
        drop     = event_ok && fifo_full && !pop_ok;

        wr_entry = '0;
        wr_entry[BOFF +: pBUFFER_SIZE] = I_matching_buffer;
        wr_entry[MOFF]                 = ev_multi;
        wr_entry[ROFF +: RW]           = ev_rule;
        wr_entry[TOFF +: pTS_WIDTH]    = ts_q;
    end

    always_comb begin
        ts_d       = I_clear ? '0 : (I_synchronized ? ts_q + pTS_WIDTH'(1) : ts_q);
        prev_d     = I_synchronized ? I_matching_pattern : '0;
        ev_cnt_inc = ev_cnt_q + 8'd1;

        state_d  = state_q;
        ev_cnt_d = ev_cnt_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (I_clear) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (I_disarm) begin
            state_d = ST_IDLE;
        end else if (I_arm) begin
            state_d  = ST_ARMED;
            ev_cnt_d = '0;
        end else if (push) begin
            ev_cnt_d = ev_cnt_inc;
            if ((I_max_events != '0) && (ev_cnt_inc == I_max_events)) state_d = ST_DONE;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            if (I_stop_on_full) state_d = ST_DONE;
        end
    end

    always_ff @(posedge trace_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ts_q     <= '0;
            prev_q   <= '0;
            ev_cnt_q <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            ts_q     <= ts_d;
            prev_q   <= prev_d;
            ev_cnt_q <= ev_cnt_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    trace_event_fifo #(
        .DEPTH (pFIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (trace_clk),
        .rst     (reset),
        .flush   (I_clear),
        .push    (push),
        .pop     (pop_ok),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (O_count)
    );

    assign O_rd_buffer    = rd_entry[BOFF +: pBUFFER_SIZE];
    assign O_rd_multi     = rd_entry[MOFF];
    assign O_rd_rule      = rd_entry[ROFF +: RW];
    assign O_rd_timestamp = rd_entry[TOFF +: pTS_WIDTH];
    assign O_empty        = fifo_empty;
    assign O_full         = fifo_full;
    assign O_overflow     = ovf_q;
    assign O_drop_count   = drop_q;
    assign O_state        = state_q;
    assign O_timestamp    = ts_q;

endmodule

// File: tb/tb_trace_match_recorder.sv
// Directed and randomized bench for trace_match_recorder against a queue-based event model.
module tb_trace_match_recorder;
    localparam int BS = 64;
    localparam int MR = 8;
    localparam int TW = 32;
    localparam int FD = 16;

    logic          trace_clk = 1'b0;
    logic          reset;
    logic          i_arm, i_disarm, i_clear, i_sof, i_sync, i_rd;
    logic [7:0]    i_max;
    logic [MR-1:0] i_pat;
    logic [BS-1:0] i_buf;

    logic [TW-1:0] o_rd_ts;
    logic [2:0]    o_rd_rule;
    logic          o_rd_multi;
    logic [BS-1:0] o_rd_buf;
    logic          o_empty, o_full, o_ovf;
    logic [4:0]    o_count;
    logic [7:0]    o_drop;
    logic [1:0]    o_state;
    logic [TW-1:0] o_ts;

    trace_match_recorder #(
        .pBUFFER_SIZE (BS),
        .pMATCH_RULES (MR),
        .pTS_WIDTH    (TW),
        .pFIFO_DEPTH  (FD)
    ) dut (
        .trace_clk          (trace_clk),
        .reset              (reset),
        .I_arm              (i_arm),
        .I_disarm           (i_disarm),
        .I_clear            (i_clear),
        .I_stop_on_full     (i_sof),
        .I_max_events       (i_max),
        .I_synchronized     (i_sync),
        .I_matching_pattern (i_pat),
        .I_matching_buffer  (i_buf),
        .I_rd_en            (i_rd),
        .O_rd_timestamp     (o_rd_ts),
        .O_rd_rule          (o_rd_rule),
        .O_rd_multi         (o_rd_multi),
        .O_rd_buffer        (o_rd_buf),
        .O_empty            (o_empty),
        .O_full             (o_full),
        .O_count            (o_count),
        .O_overflow         (o_ovf),
        .O_drop_count       (o_drop),
        .O_state            (o_state),
        .O_timestamp        (o_ts)
    );

    always #5 trace_clk = ~trace_clk;

    typedef struct {
        logic [TW-1:0] ts;
        int            rule;
        bit            multi;
        logic [BS-1:0] bufv;
    } ent_t;

    ent_t          mq[$];
    logic [TW-1:0] m_ts;
    logic [MR-1:0] m_prev;
    int            m_state;
    logic [7:0]    m_cnt;
    bit            m_ovf;
    int            m_drop;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [MR-1:0] v);
        for (int b = 0; b < MR; b++) if (v[b]) return b;
        return 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ts = '0; m_prev = '0; m_state = 0; m_cnt = '0; m_ovf = 0; m_drop = 0;
    endtask

    task automatic check_all();
        chk("state", 64'(o_state), 64'(m_state));
        chk("timestamp", 64'(o_ts), 64'(m_ts));
        chk("empty", 64'(o_empty), 64'(mq.size() == 0));
        chk("full", 64'(o_full), 64'(mq.size() == FD));
        chk("count", 64'(o_count), 64'(mq.size()));
        chk("overflow", 64'(o_ovf), 64'(m_ovf));
        chk("drop_count", 64'(o_drop), 64'(m_drop));
        if (mq.size() > 0) begin
            chk("head_ts", 64'(o_rd_ts), 64'(mq[0].ts));
            chk("head_rule", 64'(o_rd_rule), 64'(mq[0].rule));
            chk("head_multi", 64'(o_rd_multi), 64'(mq[0].multi));
            chk("head_buffer", o_rd_buf, mq[0].bufv);
        end else begin
            chk("idle_head", 64'(o_rd_ts) | 64'(o_rd_rule) | 64'(o_rd_multi) | o_rd_buf, 64'd0);
        end
    endtask

    // Applies the current inputs to the model, clocks once, then compares.
    task automatic cyc();
        logic [MR-1:0] nw;
        bit   ev, pop;
        ent_t e;
        nw  = i_pat & ~m_prev;
        ev  = (nw != 0) && (m_state == 1) && i_sync && !i_clear && !i_disarm && !i_arm;
        pop = i_rd && (mq.size() > 0) && !i_clear;
        if (i_clear) begin
            mq.delete(); m_ovf = 0; m_drop = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (i_disarm) m_state = 0;
            else if (i_arm) begin m_state = 1; m_cnt = '0; end
            else if (ev) begin
                if (mq.size() < FD) begin
                    e.ts = m_ts; e.rule = lowest(nw); e.multi = ($countones(nw) > 1); e.bufv = i_buf;
                    mq.push_back(e);
                    m_cnt = m_cnt + 8'd1;
                    if (i_max != 0 && m_cnt == i_max) m_state = 2;
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                    if (i_sof) m_state = 2;
                end
            end
        end
        m_ts   = i_clear ? '0 : (i_sync ? m_ts + 1 : m_ts);
        m_prev = i_sync ? i_pat : '0;
        @(posedge trace_clk);
        #1;
        check_all();
    endtask

    task automatic pulse_clear();
        i_clear = 1; cyc(); i_clear = 0;
    endtask

    task automatic one_event(input logic [MR-1:0] p);
        i_pat = p; i_buf = {$urandom, $urandom}; cyc();
        i_pat = '0; cyc();
    endtask

    initial begin
        logic [TW-1:0] t_edge;
        logic [TW-1:0] last_ts;
        reset = 1; i_arm = 0; i_disarm = 0; i_clear = 0; i_sof = 0; i_sync = 0; i_rd = 0;
        i_max = '0; i_pat = '0; i_buf = '0;
        model_reset();
        #1;
        check_all();
        @(negedge trace_clk);
        reset = 0;

        // Single rising rule held for several cycles gives one entry.
        i_sync = 1; i_arm = 1; cyc(); i_arm = 0;
        t_edge = m_ts;
        i_pat = 8'h04; i_buf = {$urandom, $urandom}; cyc();
        chk("t1_rule", 64'(o_rd_rule), 64'd2);
        chk("t1_multi", 64'(o_rd_multi), 64'd0);
        chk("t1_ts", 64'(o_rd_ts), 64'(t_edge));
        chk("t1_empty", 64'(o_empty), 64'd0);
        for (int k = 0; k < 4; k++) cyc();
        chk("t1_count", 64'(o_count), 64'd1);

        i_pat = '0; i_rd = 1; cyc(); i_rd = 0;
        i_pat = 8'h0A; i_buf = {$urandom, $urandom}; cyc();
        chk("t2_rule", 64'(o_rd_rule), 64'd1);
        chk("t2_multi", 64'(o_rd_multi), 64'd1);
        i_pat = '0; i_rd = 1; cyc(); i_rd = 0;

        // Overflow without stop-on-full.
        pulse_clear();
        for (int k = 0; k < 20; k++) one_event(8'($urandom_range(1, 255)));
        chk("ovf_count", 64'(o_count), 64'd16);
        chk("ovf_flag", 64'(o_ovf), 64'd1);
        chk("ovf_drops", 64'(o_drop), 64'd4);
        chk("ovf_state", 64'(o_state), 64'd1);

        // Full with a same-cycle pop: push accepted at the tail.
        i_pat = 8'h80; i_rd = 1; cyc(); i_rd = 0; i_pat = '0;
        chk("fullpop_count", 64'(o_count), 64'd16);
        chk("fullpop_drops", 64'(o_drop), 64'd4);
        last_ts = '0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) chk("drain_ts_increasing", 64'(o_rd_ts > last_ts), 64'd1);
            if (k == 15) chk("tail_rule", 64'(o_rd_rule), 64'd7);
            last_ts = o_rd_ts;
            i_rd = 1; cyc();
        end
        i_rd = 0;
        chk("drained_empty", 64'(o_empty), 64'd1);

        // Event limit stops recording; re-arm keeps the FIFO.
        pulse_clear();
        i_max = 8'd3; i_arm = 1; cyc(); i_arm = 0;
        for (int k = 0; k < 5; k++) one_event(8'($urandom_range(1, 255)));
        chk("max_count", 64'(o_count), 64'd3);
        chk("max_state", 64'(o_state), 64'd2);
        i_arm = 1; cyc(); i_arm = 0;
        chk("rearm_state", 64'(o_state), 64'd1);
        chk("rearm_count", 64'(o_count), 64'd3);
        i_max = '0;

        // Asynchronous reset mid-capture.
        pulse_clear();
        for (int k = 0; k < 5; k++) one_event(8'($urandom_range(1, 255)));
        chk("pre_reset_count", 64'(o_count), 64'd5);
        #2 reset = 1;
        #1;
        chk("rst_empty", 64'(o_empty), 64'd1);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_ts", 64'(o_ts), 64'd0);
        chk("rst_state", 64'(o_state), 64'd0);
        model_reset();
        @(negedge trace_clk);
        reset = 0;
        cyc();
        i_arm = 1; cyc(); i_arm = 0;
        for (int k = 0; k < 3; k++) one_event(8'($urandom_range(1, 255)));
        pulse_clear();
        chk("clear_empty", 64'(o_empty), 64'd1);
        chk("clear_state", 64'(o_state), 64'd1);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            if (k % 100 == 0) begin
                i_sof = 1'($urandom_range(0, 1));
                i_max = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 20)) : 8'd0;
            end
            i_arm    = ($urandom_range(0, 24) == 0);
            i_disarm = ($urandom_range(0, 59) == 0);
            i_clear  = ($urandom_range(0, 79) == 0);
            i_sync   = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 1) == 0) i_pat = 8'($urandom);
            i_rd     = ($urandom_range(0, 3) == 0);
            i_buf    = {$urandom, $urandom};
            cyc();
        end
        i_arm = 0; i_disarm = 0; i_clear = 0; i_rd = 0; i_pat = '0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
